// File: rtl/jtag_scan_ctrl.sv
// jtag_scan_ctrl: command-driven JTAG scan master producing cycle-exact TMS/TDI and capturing TDO
module jtag_scan_ctrl #(
    parameter int REG_W = 8,
    parameter int LEN_W = $clog2(REG_W) + 1
) (
    input  logic             i_tclk,
    input  logic             i_trst,
    input  logic             i_cmdValid,
    output logic             o_cmdReady,
    input  logic [1:0]       i_cmdOp,
    input  logic [LEN_W-1:0] i_cmdLen,
    input  logic [REG_W-1:0] i_cmdData,
    output logic             o_rspValid,
    input  logic             i_rspReady,
    output logic [REG_W-1:0] o_rspData,
    output logic             o_tms,
    output logic             o_tdi,
    input  logic             i_tdo,
    output logic             o_busy
);
    localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TLR_ONES = CNT_W'(5);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(REG_W);
    localparam logic [1:0] OP_TLR = 2'b00;
    localparam logic [1:0] OP_IR = 2'b01;
    localparam logic [1:0] OP_DR = 2'b10;
    localparam logic [1:0] OP_IDLE = 2'b11;

    typedef enum logic [3:0] {INIT, IDLE, TLR, HDR, SHIFT, EXIT, UPD, WAIT, RSP} stateT;

    stateT state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] scanLen;
    logic isIr;
    logic [REG_W-1:0] shiftData;
    logic [LEN_W-1:0] effLen;
    logic [CNT_W-1:0] hdrLen;
    logic hdrTms;
    logic [LEN_W-1:0] alignShift;

    assign o_cmdReady = (state == IDLE);
    assign o_busy = (state != IDLE);

    // Clamp the scan length and derive the header shape of the scan in flight
    always_comb begin
        effLen = (i_cmdLen == '0 || i_cmdLen > FULL_LEN) ? FULL_LEN : i_cmdLen;
        hdrLen = isIr ? CNT_W'(4) : CNT_W'(3);
        hdrTms = cnt < (isIr ? CNT_W'(2) : ONE);
        alignShift = FULL_LEN - scanLen[LEN_W-1:0];
    end

    // Sequencer: each edge decides the next TMS/TDI bit; cnt counts bits already driven
    always_ff @(posedge i_tclk or posedge i_trst) begin
        if (i_trst) begin
            state <= INIT;
            cnt <= '0;
            scanLen <= '0;
            isIr <= 1'b0;
            shiftData <= '0;
            o_tms <= 1'b1;
            o_tdi <= 1'b0;
            o_rspValid <= 1'b0;
            o_rspData <= '0;
        end else begin
            case (state)
                INIT, TLR: begin
                    if (cnt < TLR_ONES) begin
                        o_tms <= 1'b1;
                        cnt <= cnt + ONE;
                    end else if (cnt == TLR_ONES) begin
                        o_tms <= 1'b0;
                        cnt <= cnt + ONE;
                    end else begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    o_tms <= 1'b0;
                    o_tdi <= 1'b0;
                    if (i_cmdValid) begin
                        case (i_cmdOp)
                            OP_TLR: begin
                                state <= TLR;
                                o_tms <= 1'b1;
                                cnt <= ONE;
                            end
                            OP_IR, OP_DR: begin
                                state <= HDR;
                                o_tms <= 1'b1;
                                cnt <= ONE;
                                isIr <= (i_cmdOp == OP_IR);
                                scanLen <= CNT_W'(effLen);
                                shiftData <= i_cmdData;
                            end
                            OP_IDLE: begin
                                state <= WAIT;
                                cnt <= CNT_W'(i_cmdLen);
                            end
                        endcase
                    end
                end
                HDR: begin
                    if (cnt < hdrLen) begin
                        o_tms <= hdrTms;
                        cnt <= cnt + ONE;
                    end else begin
                        o_tms <= (scanLen == ONE);
                        o_tdi <= shiftData[0];
                        shiftData <= shiftData >> 1;
                        cnt <= ONE;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    o_rspData <= {i_tdo, o_rspData[REG_W-1:1]};
                    if (cnt < scanLen) begin
                        o_tms <= (cnt == scanLen - ONE);
                        o_tdi <= shiftData[0];
                        shiftData <= shiftData >> 1;
                        cnt <= cnt + ONE;
                    end else begin
                        o_tms <= 1'b1;
                        o_tdi <= 1'b0;
                        state <= EXIT;
                    end
                end
                EXIT: begin
                    o_tms <= 1'b0;
                    o_rspData <= o_rspData >> alignShift;
                    state <= UPD;
                end
                UPD: begin
                    o_rspValid <= 1'b1;
                    state <= RSP;
                end
                RSP: begin
                    if (i_rspReady) begin
                        o_rspValid <= 1'b0;
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt <= ONE) state <= IDLE;
                    else cnt <= cnt - ONE;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule
